lcd_sw_spi_master: RTL and testbench

//  SPI master engine serving the front-panel LCD/switch controller: takes one 24-bit frame per start strobe,

---
 rtl/lcd_sw_pkg.sv | 27 ++
 rtl/lcd_sw_spi_master_if.sv | 26 ++
 rtl/lcd_sw_spi_clk_en.sv | 48 ++++
 rtl/lcd_sw_spi_master.sv | 174 +++++++++++++++++
 tb/tb_lcd_sw_spi_master.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_sw_pkg.sv
// Shared definitions for the front-panel LCD/switch SPI path: FSM encoding,
// default frame width and chip-select polarities.
package lcd_sw_pkg;

    localparam int DATA_W_DEF = 24;

    localparam logic LCD_CS_ACT = 1'b1;
    localparam logic SW_CS_ACT  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_e;

    // Returns {lcd_cs, sw_cs_n}; only the selected target can ever be active.
    function automatic logic [1:0] cs_drive(input logic sel_sw, input logic active);
        logic lcd_cs;
        logic sw_cs_n;
        lcd_cs  = (active && !sel_sw) ? LCD_CS_ACT : ~LCD_CS_ACT;
        sw_cs_n = (active &&  sel_sw) ? SW_CS_ACT  : ~SW_CS_ACT;
        return {lcd_cs, sw_cs_n};
    endfunction

endpackage

// File: rtl/lcd_sw_spi_master_if.sv
// Frame request/response handshake between the upstream LCD/switch controller
// and the SPI engine.
interface lcd_sw_spi_master_if
    import lcd_sw_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              spi_start;
    logic [DATA_W-1:0] mosi_data;
    logic              lcd_sw_cs;
    logic [DATA_W-1:0] miso_data;
    logic              busy;
    logic              done;

    modport master (
        output spi_start, mosi_data, lcd_sw_cs,
        input  miso_data, busy, done
    );

    modport slave (
        input  spi_start, mosi_data, lcd_sw_cs,
        output miso_data, busy, done
    );

endinterface

// File: rtl/lcd_sw_spi_clk_en.sv
// SCLK timing for the SPI engine: half-period counter plus single-cycle
// rise/fall enables, held in reset whenever the engine is not shifting.
module lcd_sw_spi_clk_en #(
    parameter int CLK_DIV = 50
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic en,
    output logic rise_en,
    output logic fall_en
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             wrap;

    assign wrap    = en && (cnt_q == CNT_W'(CLK_DIV - 1));
    // phase_q mirrors the SCLK level the engine is currently driving.
    assign rise_en = wrap && !phase_q;
    assign fall_en = wrap &&  phase_q;

    always_comb begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (en) begin
            if (wrap) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                phase_d = phase_q;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/lcd_sw_spi_master.sv
// SPI mode-0 master for the front-panel LCD (CS high) and switch expander
// (CS low): one full-duplex DATA_W-bit frame per accepted start strobe.
module lcd_sw_spi_master
    import lcd_sw_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CLK_DIV  = 50,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    lcd_sw_spi_master_if.slave ctrl,
    output logic               o_sclk,
    output logic               o_mosi,
    input  logic               i_miso,
    output logic               o_lcd_cs,
    output logic               o_sw_cs_n
);

    localparam int TMR_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int BIT_W   = $clog2(DATA_W);

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] miso_data_q, miso_data_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              sel_sw_q, sel_sw_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              lcd_cs_q, lcd_cs_d;
    logic              sw_cs_n_q, sw_cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rise_en, fall_en;

    lcd_sw_spi_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_en (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .en      (state_q == ST_SHIFT),
        .rise_en (rise_en),
        .fall_en (fall_en)
    );

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        miso_data_d = miso_data_q;
        bit_d       = bit_q;
        tmr_d       = tmr_q;
        sel_sw_d    = sel_sw_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        lcd_cs_d    = lcd_cs_q;
        sw_cs_n_d   = sw_cs_n_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ctrl.spi_start) begin
                    // First MOSI bit is presented together with CS assert.
                    tx_d                   = ctrl.mosi_data;
                    sel_sw_d               = ctrl.lcd_sw_cs;
                    mosi_d                 = ctrl.mosi_data[DATA_W-1];
                    {lcd_cs_d, sw_cs_n_d}  = cs_drive(ctrl.lcd_sw_cs, 1'b1);
                    rx_d                   = '0;
                    bit_d                  = '0;
                    tmr_d                  = '0;
                    busy_d                 = 1'b1;
                    state_d                = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (tmr_q == TMR_W'(CS_SETUP - 1)) begin
                    tmr_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            ST_SHIFT: begin
                if (rise_en) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[DATA_W-2:0], i_miso};
                end
                if (fall_en) begin
                    sclk_d = 1'b0;
                    tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                    mosi_d = tx_q[DATA_W-2];
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        bit_d   = '0;
                        tmr_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (tmr_q == TMR_W'(CS_HOLD - 1)) begin
                    tmr_d                  = '0;
                    {lcd_cs_d, sw_cs_n_d}  = cs_drive(sel_sw_q, 1'b0);
                    mosi_d                 = 1'b0;
                    miso_data_d            = rx_q;
                    done_d                 = 1'b1;
                    state_d                = ST_DONE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            ST_DONE: begin
                // Starts arriving here are dropped; busy is still high.
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            miso_data_q <= '0;
            bit_q       <= '0;
            tmr_q       <= '0;
            sel_sw_q    <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            lcd_cs_q    <= ~LCD_CS_ACT;
            sw_cs_n_q   <= ~SW_CS_ACT;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            miso_data_q <= miso_data_d;
            bit_q       <= bit_d;
            tmr_q       <= tmr_d;
            sel_sw_q    <= sel_sw_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            lcd_cs_q    <= lcd_cs_d;
            sw_cs_n_q   <= sw_cs_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_sclk         = sclk_q;
    assign o_mosi         = mosi_q;
    assign o_lcd_cs       = lcd_cs_q;
    assign o_sw_cs_n      = sw_cs_n_q;
    assign ctrl.miso_data = miso_data_q;
    assign ctrl.busy      = busy_q;
    assign ctrl.done      = done_q;

endmodule

// File: tb/tb_lcd_sw_spi_master.sv
// Scoreboard bench for lcd_sw_spi_master: stimulus pushes expected frames,
// a negedge monitor checks completed frames, requested checks and the SPI protocol.
module tb_lcd_sw_spi_master;

    localparam int DW      = 24;
    localparam int LATENCY = 197;

    typedef struct {
        logic [DW-1:0] rx;
        logic [DW-1:0] tx;
        logic          sw;
        int            start_cyc;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic clk = 1'b0;
    logic rst_n;
    logic sclk, mosi, lcd_cs, sw_cs_n;
    logic miso;
    logic cs_act;

    lcd_sw_spi_master_if #(.DATA_W(DW)) ifc ();

    lcd_sw_spi_master #(
        .DATA_W   (DW),
        .CLK_DIV  (4),
        .CS_SETUP (2),
        .CS_HOLD  (2)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .ctrl      (ifc),
        .o_sclk    (sclk),
        .o_mosi    (mosi),
        .i_miso    (miso),
        .o_lcd_cs  (lcd_cs),
        .o_sw_cs_n (sw_cs_n)
    );

    always #5 clk = ~clk;

    assign cs_act = lcd_cs | ~sw_cs_n;

    exp_t          exp_q[$];
    chk_t          chk_q[$];
    int            errors   = 0;
    int            checks   = 0;
    int            done_cnt = 0;
    int            cyc      = 0;
    logic [DW-1:0] slave_resp = '0;
    logic [DW-1:0] slave_sh   = '0;
    logic          cs_prev    = 1'b0;
    logic [DW-1:0] cap        = '0;
    int            rise_cnt   = 0;
    logic          lcd_seen   = 1'b0;
    logic          sw_seen    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Mode-0 slave: first bit valid at CS assert, next bit after each SCLK fall.
    assign miso = slave_sh[DW-1];
    always @(cs_act or negedge sclk) begin
        if (cs_act && !cs_prev)
            slave_sh = slave_resp;
        else if (cs_act && !sclk)
            slave_sh = slave_sh << 1;
        cs_prev = cs_act;
    end

    always @(posedge cs_act or posedge sclk) begin
        if (sclk) begin
            cap      = {cap[DW-2:0], mosi};
            rise_cnt = rise_cnt + 1;
        end else begin
            cap      = '0;
            rise_cnt = 0;
            lcd_seen = lcd_cs;
            sw_seen  = ~sw_cs_n;
        end
    end

    task automatic tally(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Single checking process: scoreboard, requested checks, protocol rules.
    logic prev_sclk = 1'b0, prev_mosi = 1'b0, prev_lcd = 1'b0, prev_sw = 1'b1, prev_rst = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        chk_t c;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            tally(c.name, c.act, c.exp);
        end
        if (ifc.done === 1'b1) begin
            done_cnt = done_cnt + 1;
            if (exp_q.size() == 0) begin
                tally("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                tally("miso_data", 32'(ifc.miso_data), 32'(e.rx));
                tally("mosi_word", 32'(cap), 32'(e.tx));
                tally("sclk_rises", 32'(rise_cnt), 32'd24);
                tally("latency", 32'(cyc - e.start_cyc), 32'(LATENCY));
                tally("lcd_cs_used", 32'(lcd_seen), 32'(!e.sw));
                tally("sw_cs_used", 32'(sw_seen), 32'(e.sw));
                tally("busy_in_done", 32'(ifc.busy), 32'd1);
                $display("frame done: tx=0x%06h rx=0x%06h target=%s cyc=%0d",
                         cap, ifc.miso_data, e.sw ? "sw" : "lcd", cyc);
            end
        end
        if (rst_n && prev_rst) begin
            tally("mosi_stable_sclk_high",
                  32'(prev_sclk && sclk && (mosi !== prev_mosi)), 32'd0);
            tally("cs_edge_sclk_low",
                  32'(((lcd_cs !== prev_lcd) || (sw_cs_n !== prev_sw)) && (sclk || prev_sclk)), 32'd0);
            tally("both_cs_active", 32'(lcd_cs && !sw_cs_n), 32'd0);
        end
        prev_sclk = sclk;
        prev_mosi = mosi;
        prev_lcd  = lcd_cs;
        prev_sw   = sw_cs_n;
        prev_rst  = rst_n;
    end

    task automatic req(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic req_idle(input string tag);
        req({tag, "_sclk"},      32'(sclk),          32'd0);
        req({tag, "_mosi"},      32'(mosi),          32'd0);
        req({tag, "_lcd_cs"},    32'(lcd_cs),        32'd0);
        req({tag, "_sw_cs_n"},   32'(sw_cs_n),       32'd1);
        req({tag, "_miso_data"}, 32'(ifc.miso_data), 32'd0);
        req({tag, "_busy"},      32'(ifc.busy),      32'd0);
        req({tag, "_done"},      32'(ifc.done),      32'd0);
    endtask

    task automatic issue(input logic [DW-1:0] tx, input logic sw, input logic [DW-1:0] resp,
                         input bit expect_frame);
        exp_t e;
        @(negedge clk);
        if (expect_frame || !ifc.busy) slave_resp = resp;
        ifc.mosi_data = tx;
        ifc.lcd_sw_cs = sw;
        ifc.spi_start = 1'b1;
        if (expect_frame) begin
            e.rx        = resp;
            e.tx        = tx;
            e.sw        = sw;
            e.start_cyc = cyc;
            exp_q.push_back(e);
        end
        $display("start: tx=0x%06h target=%s resp=0x%06h expect=%0d", tx, sw ? "sw" : "lcd", resp, expect_frame);
        @(negedge clk);
        ifc.spi_start = 1'b0;
    endtask

    task automatic wait_done();
        int  base;
        bit  seen;
        base = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != base) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) req("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int base;
        rst_n         = 1'b0;
        ifc.spi_start = 1'b0;
        ifc.mosi_data = '0;
        ifc.lcd_sw_cs = 1'b0;
        repeat (3) @(negedge clk);
        req_idle("in_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        req_idle("after_reset");

        // 1: LCD write
        issue(24'hF85040, 1'b0, 24'h123456, 1'b1);
        wait_done();

        // 2: switch read
        issue(24'h410900, 1'b1, 24'h0000A5, 1'b1);
        wait_done();
        @(negedge clk);
        req("sw_read_hold", 32'(ifc.miso_data), 32'h0000A5);

        // 3: start mid-frame is dropped
        base = done_cnt;
        issue(24'h55AA33, 1'b0, 24'hC3C3C3, 1'b1);
        repeat (8) @(negedge clk);
        issue(24'hFFFFFF, 1'b1, 24'h0F0F0F, 1'b0);
        wait_done();
        repeat (10) @(negedge clk);
        #1;
        req("single_done", 32'(done_cnt - base), 32'd1);

        // 4: back-to-back, start in the first idle clk after done
        issue(24'h0F0F0F, 1'b0, 24'hA1B2C3, 1'b1);
        wait_done();
        issue(24'h3C3C3C, 1'b1, 24'h5A5A5A, 1'b1);
        repeat (100) @(negedge clk);
        req("miso_hold_frame1", 32'(ifc.miso_data), 32'hA1B2C3);
        req("busy_mid_frame", 32'(ifc.busy), 32'd1);
        wait_done();

        // 5: async reset at the 12th SCLK rise aborts the frame
        base = done_cnt;
        issue(24'h123456, 1'b0, 24'h777777, 1'b0);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (rise_cnt == 12 && sclk) break;
        end
        req("abort_at_rise12", 32'(rise_cnt), 32'd12);
        rst_n = 1'b0;
        #1;
        req_idle("abort");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        req("abort_no_done", 32'(done_cnt - base), 32'd0);
        issue(24'h9ABCDE, 1'b0, 24'h2468AC, 1'b1);
        wait_done();

        repeat (3) @(negedge clk);
        req("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        req("total_done", 32'(done_cnt), 32'd6);
        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
